// File: rtl/number_splitter.sv
// ============================================================================
//  Module      : number_splitter
//  Description : Binary-to-decimal token streamer. Serial double-dabble, then
//                MS-digit-first 4-bit tokens over valid/ready. Define
//                SIGNED_EN for two's-complement input with a leading minus token.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module number_splitter #(
    parameter int         WIDTH       = 32,
    parameter int         DIGITS      = 10,
    parameter logic [3:0] MINUS_TOKEN = 4'hB
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] number,
    output logic             busy,
    output logic [3:0]       token,
    output logic             token_valid,
    input  logic             token_ready,
    output logic             token_last,
    output logic             done
);

    localparam int c_BW = DIGITS * 4;
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_ALIGN = 3'd2,
        S_SIGN  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [c_BW-1:0]   r_bcd;
    logic [c_CW-1:0]   r_cnt;
    logic [c_IW-1:0]   r_idx;
    logic              r_neg;

    logic              w_neg;
    logic [WIDTH-1:0]  w_mag;
    logic [c_BW-1:0]   w_adj;
    logic [c_IW-1:0]   w_msd;
    logic [c_IW-1:0]   w_idx_dec;
    logic              w_hs;

`ifdef SIGNED_EN
    assign w_neg = number[WIDTH-1];
    assign w_mag = number[WIDTH-1] ? (~number + 1'b1) : number;
`else
    assign w_neg = 1'b0;
    assign w_mag = number;
`endif

    assign w_idx_dec = r_idx - c_IW'(1);
    assign w_hs      = token_valid & token_ready;

    function automatic logic [3:0] digit_at(input logic [c_BW-1:0] bcd,
                                            input logic [c_IW-1:0] idx);
        logic [3:0] result;
        result = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx == c_IW'(d)) result = bcd[d*4 +: 4];
        end
        return result;
    endfunction

    // Double-dabble correction applied before each shift
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
        end
    end

    // Highest nonzero digit; an all-zero result leaves index 0 so "0" is emitted
    always_comb begin
        w_msd = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] != 4'd0) w_msd = c_IW'(d);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_neg       <= 1'b0;
            busy        <= 1'b0;
            token       <= 4'd0;
            token_valid <= 1'b0;
            token_last  <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= w_mag;
                        r_neg   <= w_neg;
                        r_bcd   <= '0;
                        r_cnt   <= c_CW'(WIDTH);
                        busy    <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_shift} <= {w_adj[c_BW-2:0], r_shift, 1'b0};
                    r_cnt            <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) r_state <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_idx   <= w_msd;
                    r_state <= r_neg ? S_SIGN : S_EMIT;
                end
                S_SIGN: begin
                    if (!token_valid) begin
                        token       <= MINUS_TOKEN;
                        token_last  <= 1'b0;
                        token_valid <= 1'b1;
                    end else if (token_ready) begin
                        // Sign accepted: first digit follows with no bubble
                        token      <= digit_at(r_bcd, r_idx);
                        token_last <= (r_idx == '0);
                        r_state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!token_valid) begin
                        token       <= digit_at(r_bcd, r_idx);
                        token_last  <= (r_idx == '0);
                        token_valid <= 1'b1;
                    end else if (w_hs) begin
                        if (r_idx == '0) begin
                            token       <= 4'd0;
                            token_valid <= 1'b0;
                            token_last  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx      <= w_idx_dec;
                            token      <= digit_at(r_bcd, w_idx_dec);
                            token_last <= (w_idx_dec == '0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
